decode_queue: RTL

Parametrised decode-and-buffer stage between instruction fetch and dispatch. Each accepted fetch word is decoded in the cycle it arrives: opnum, register indices, sign-extended immediate, jump/load-store/illegal flags. The decoded record is written into a DEPTH-entry circular queue. Dispatch drains the queue in order through a valid/ready handshake. A flush input clears all speculative entries on branch mispredict.

---
 rtl/decode_queue.sv | 337 +++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/decode_queue.sv
`default_nettype none
// ============================================================================
//  Module      : decode_queue
//  Description : Decodes each accepted fetch word and buffers the decoded
//                record in a DEPTH-entry circular queue drained in order by
//                dispatch over a valid/ready handshake. Flush discards all
//                entries.
//  Option      : DECODE_QUEUE_TARGET_EN - when defined, JAL and branch
//                entries carry a precomputed pc + imm target; otherwise
//                out_target is tied to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module decode_queue #(
  parameter int DEPTH   = 8,
  parameter int OPNUM_W = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rdy,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_inst,
  input  logic [31:0]                in_pc,
  input  logic                       in_pred_taken,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OPNUM_W-1:0]         out_opnum,
  output logic [4:0]                 out_rd,
  output logic [4:0]                 out_rs1,
  output logic [4:0]                 out_rs2,
  output logic [31:0]                out_imm,
  output logic [31:0]                out_pc,
  output logic                       out_pred_taken,
  output logic                       out_is_jump,
  output logic                       out_is_ls,
  output logic                       out_illegal,
  output logic [31:0]                out_target,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  // Opnum encodings, mirroring the shared defines header
  localparam logic [OPNUM_W-1:0] OPNUM_NULL  = OPNUM_W'(0);
  localparam logic [OPNUM_W-1:0] OPNUM_LUI   = OPNUM_W'(1);
  localparam logic [OPNUM_W-1:0] OPNUM_AUIPC = OPNUM_W'(2);
  localparam logic [OPNUM_W-1:0] OPNUM_JAL   = OPNUM_W'(3);
  localparam logic [OPNUM_W-1:0] OPNUM_JALR  = OPNUM_W'(4);
  localparam logic [OPNUM_W-1:0] OPNUM_BEQ   = OPNUM_W'(5);
  localparam logic [OPNUM_W-1:0] OPNUM_BNE   = OPNUM_W'(6);
  localparam logic [OPNUM_W-1:0] OPNUM_BLT   = OPNUM_W'(7);
  localparam logic [OPNUM_W-1:0] OPNUM_BGE   = OPNUM_W'(8);
  localparam logic [OPNUM_W-1:0] OPNUM_BLTU  = OPNUM_W'(9);
  localparam logic [OPNUM_W-1:0] OPNUM_BGEU  = OPNUM_W'(10);
  localparam logic [OPNUM_W-1:0] OPNUM_LB    = OPNUM_W'(11);
  localparam logic [OPNUM_W-1:0] OPNUM_LH    = OPNUM_W'(12);
  localparam logic [OPNUM_W-1:0] OPNUM_LW    = OPNUM_W'(13);
  localparam logic [OPNUM_W-1:0] OPNUM_LBU   = OPNUM_W'(14);
  localparam logic [OPNUM_W-1:0] OPNUM_LHU   = OPNUM_W'(15);
  localparam logic [OPNUM_W-1:0] OPNUM_SB    = OPNUM_W'(16);
  localparam logic [OPNUM_W-1:0] OPNUM_SH    = OPNUM_W'(17);
  localparam logic [OPNUM_W-1:0] OPNUM_SW    = OPNUM_W'(18);
  localparam logic [OPNUM_W-1:0] OPNUM_ADDI  = OPNUM_W'(19);
  localparam logic [OPNUM_W-1:0] OPNUM_SLTI  = OPNUM_W'(20);
  localparam logic [OPNUM_W-1:0] OPNUM_SLTIU = OPNUM_W'(21);
  localparam logic [OPNUM_W-1:0] OPNUM_XORI  = OPNUM_W'(22);
  localparam logic [OPNUM_W-1:0] OPNUM_ORI   = OPNUM_W'(23);
  localparam logic [OPNUM_W-1:0] OPNUM_ANDI  = OPNUM_W'(24);
  localparam logic [OPNUM_W-1:0] OPNUM_SLLI  = OPNUM_W'(25);
  localparam logic [OPNUM_W-1:0] OPNUM_SRLI  = OPNUM_W'(26);
  localparam logic [OPNUM_W-1:0] OPNUM_SRAI  = OPNUM_W'(27);
  localparam logic [OPNUM_W-1:0] OPNUM_ADD   = OPNUM_W'(28);
  localparam logic [OPNUM_W-1:0] OPNUM_SUB   = OPNUM_W'(29);
  localparam logic [OPNUM_W-1:0] OPNUM_SLL   = OPNUM_W'(30);
  localparam logic [OPNUM_W-1:0] OPNUM_SLT   = OPNUM_W'(31);
  localparam logic [OPNUM_W-1:0] OPNUM_SLTU  = OPNUM_W'(32);
  localparam logic [OPNUM_W-1:0] OPNUM_XOR   = OPNUM_W'(33);
  localparam logic [OPNUM_W-1:0] OPNUM_SRL   = OPNUM_W'(34);
  localparam logic [OPNUM_W-1:0] OPNUM_SRA   = OPNUM_W'(35);
  localparam logic [OPNUM_W-1:0] OPNUM_OR    = OPNUM_W'(36);
  localparam logic [OPNUM_W-1:0] OPNUM_AND   = OPNUM_W'(37);

  // Major opcodes
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [OPNUM_W-1:0] opnum;
    logic [4:0]         rd;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [31:0]        imm;
    logic [31:0]        pc;
    logic               pred_taken;
    logic               is_jump;
    logic               is_ls;
    logic               illegal;
  } entry_t;

  // Instruction fields
  logic [6:0]  w_opc;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_u;
  logic [31:0] w_imm_j;
  logic [31:0] w_imm_sh;

  assign w_opc    = in_inst[6:0];
  assign w_f3     = in_inst[14:12];
  assign w_f7     = in_inst[31:25];
  assign w_imm_i  = {{20{in_inst[31]}}, in_inst[31:20]};
  assign w_imm_s  = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign w_imm_b  = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                     in_inst[11:8], 1'b0};
  assign w_imm_u  = {in_inst[31:12], 12'b0};
  assign w_imm_j  = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                     in_inst[30:21], 1'b0};
  assign w_imm_sh = {27'b0, in_inst[24:20]};

  entry_t w_entry;
  logic   w_legal;

  // Combinational decode of the incoming fetch word into a queue record
  always_comb begin
    w_entry            = '0;
    w_legal            = 1'b0;
    w_entry.rd         = in_inst[11:7];
    w_entry.rs1        = in_inst[19:15];
    w_entry.rs2        = in_inst[24:20];
    w_entry.pc         = in_pc;
    w_entry.pred_taken = in_pred_taken;
    case (w_opc)
      OPC_LUI: begin
        w_entry.opnum = OPNUM_LUI;   w_entry.imm = w_imm_u; w_legal = 1'b1;
      end
      OPC_AUIPC: begin
        w_entry.opnum = OPNUM_AUIPC; w_entry.imm = w_imm_u; w_legal = 1'b1;
      end
      OPC_JAL: begin
        w_entry.opnum = OPNUM_JAL;   w_entry.imm = w_imm_j; w_legal = 1'b1;
        w_entry.is_jump = 1'b1;
      end
      OPC_JALR: begin
        w_entry.opnum = OPNUM_JALR;  w_entry.imm = w_imm_i; w_legal = 1'b1;
        w_entry.is_jump = 1'b1;
      end
      OPC_BRANCH: begin
        w_entry.rd = 5'd0; w_entry.imm = w_imm_b; w_entry.is_jump = 1'b1;
        w_legal = 1'b1;
        case (w_f3)
          3'd0:    w_entry.opnum = OPNUM_BEQ;
          3'd1:    w_entry.opnum = OPNUM_BNE;
          3'd4:    w_entry.opnum = OPNUM_BLT;
          3'd5:    w_entry.opnum = OPNUM_BGE;
          3'd6:    w_entry.opnum = OPNUM_BLTU;
          3'd7:    w_entry.opnum = OPNUM_BGEU;
          default: w_legal = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        w_entry.imm = w_imm_i; w_entry.is_ls = 1'b1; w_legal = 1'b1;
        case (w_f3)
          3'd0:    w_entry.opnum = OPNUM_LB;
          3'd1:    w_entry.opnum = OPNUM_LH;
          3'd2:    w_entry.opnum = OPNUM_LW;
          3'd4:    w_entry.opnum = OPNUM_LBU;
          3'd5:    w_entry.opnum = OPNUM_LHU;
          default: w_legal = 1'b0;
        endcase
      end
      OPC_STORE: begin
        w_entry.rd = 5'd0; w_entry.imm = w_imm_s; w_entry.is_ls = 1'b1;
        w_legal = 1'b1;
        case (w_f3)
          3'd0:    w_entry.opnum = OPNUM_SB;
          3'd1:    w_entry.opnum = OPNUM_SH;
          3'd2:    w_entry.opnum = OPNUM_SW;
          default: w_legal = 1'b0;
        endcase
      end
      OPC_OPIMM: begin
        w_entry.imm = w_imm_i; w_legal = 1'b1;
        case (w_f3)
          3'd0: w_entry.opnum = OPNUM_ADDI;
          3'd2: w_entry.opnum = OPNUM_SLTI;
          3'd3: w_entry.opnum = OPNUM_SLTIU;
          3'd4: w_entry.opnum = OPNUM_XORI;
          3'd6: w_entry.opnum = OPNUM_ORI;
          3'd7: w_entry.opnum = OPNUM_ANDI;
          3'd1: begin
            w_entry.imm   = w_imm_sh;
            w_entry.opnum = OPNUM_SLLI;
            w_legal       = (w_f7 == F7_BASE);
          end
          default: begin
            w_entry.imm = w_imm_sh;
            if (w_f7 == F7_BASE)     w_entry.opnum = OPNUM_SRLI;
            else if (w_f7 == F7_ALT) w_entry.opnum = OPNUM_SRAI;
            else                     w_legal = 1'b0;
          end
        endcase
      end
      OPC_OP: begin
        if (w_f7 == F7_BASE) begin
          w_legal = 1'b1;
          case (w_f3)
            3'd0:    w_entry.opnum = OPNUM_ADD;
            3'd1:    w_entry.opnum = OPNUM_SLL;
            3'd2:    w_entry.opnum = OPNUM_SLT;
            3'd3:    w_entry.opnum = OPNUM_SLTU;
            3'd4:    w_entry.opnum = OPNUM_XOR;
            3'd5:    w_entry.opnum = OPNUM_SRL;
            3'd6:    w_entry.opnum = OPNUM_OR;
            default: w_entry.opnum = OPNUM_AND;
          endcase
        end else if (w_f7 == F7_ALT && w_f3 == 3'd0) begin
          w_legal = 1'b1; w_entry.opnum = OPNUM_SUB;
        end else if (w_f7 == F7_ALT && w_f3 == 3'd5) begin
          w_legal = 1'b1; w_entry.opnum = OPNUM_SRA;
        end
      end
      default: w_legal = 1'b0;
    endcase
    // Undecodable words still travel down the queue so commit traps in order
    if (!w_legal) begin
      w_entry.opnum   = OPNUM_NULL;
      w_entry.imm     = '0;
      w_entry.is_jump = 1'b0;
      w_entry.is_ls   = 1'b0;
    end
    w_entry.illegal = !w_legal;
  end

  // Queue state
  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             w_push;
  logic             w_pop;

  assign in_ready  = (count_q != CNT_FULL);
  assign out_valid = (count_q != '0);
  assign count     = count_q;
  assign w_push    = rdy && in_valid && in_ready && !flush;
  assign w_pop     = rdy && out_valid && out_ready && !flush;

  // Next-state pointers and occupancy; flush wins over any push or pop
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (w_push) tail_d = tail_q + 1'b1;
      if (w_pop)  head_d = head_q + 1'b1;
      if (w_push && !w_pop)      count_d = count_q + 1'b1;
      else if (!w_push && w_pop) count_d = count_q - 1'b1;
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Record storage, written at the tail on push
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (w_push) begin
      mem_q[tail_q] <= w_entry;
    end
  end

  assign out_opnum      = mem_q[head_q].opnum;
  assign out_rd         = mem_q[head_q].rd;
  assign out_rs1        = mem_q[head_q].rs1;
  assign out_rs2        = mem_q[head_q].rs2;
  assign out_imm        = mem_q[head_q].imm;
  assign out_pc         = mem_q[head_q].pc;
  assign out_pred_taken = mem_q[head_q].pred_taken;
  assign out_is_jump    = mem_q[head_q].is_jump;
  assign out_is_ls      = mem_q[head_q].is_ls;
  assign out_illegal    = mem_q[head_q].illegal;

`ifdef DECODE_QUEUE_TARGET_EN
  logic [31:0] tgt_q [DEPTH];
  logic [31:0] w_tgt;

  // JALR targets depend on a register value, so only pc-relative jumps get one
  assign w_tgt = (w_entry.is_jump && w_entry.opnum != OPNUM_JALR)
               ? (in_pc + w_entry.imm) : 32'd0;

  // Precomputed target storage, written alongside the record
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) tgt_q[i] <= '0;
    end else if (w_push) begin
      tgt_q[tail_q] <= w_tgt;
    end
  end

  assign out_target = tgt_q[head_q];
`else
  assign out_target = 32'd0;
`endif

endmodule
`default_nettype wire
